// File: rtl/hub_tile_param.sv
// hub_tile_param: parametrised hub tile router for the hierarchical ring NoC.
//
// Ports, index order 0 = CW ring, 1 = CCW ring, 2 = vertical (superhub),
// 3.. = cluster 0..N_CLUSTER-1; P = 3 + N_CLUSTER:
//   clk, rst          clock, asynchronous active-high reset
//   in_data/in_valid  P input flits (port p at [p*FLIT_W +: FLIT_W])
//   in_credit         one-cycle pulse upstream per flit dequeued (sent or dropped)
//   out_data/out_valid P registered output flits, data holds when not valid
//   out_credit        one-cycle pulse from downstream = one credit back
//   my_cluster        this hub's ring position (static after reset)
//   err_overflow      sticky per-input flag: a flit hit a full FIFO
//
// Optional build macro HUB_TILE_SHORTEST_PATH_EN: when defined, off-cluster
// flits take the shorter ring direction (ties go CW); otherwise everything
// off-cluster leaves on the CW link.
//
// Flits are registered on entry, written into a per-input FIFO one edge
// later, routed on the FIFO head and arbitrated round-robin per output, so a
// flit sampled at edge k can leave at edge k+2 at the earliest.
module hub_tile_param #(
  parameter int FLIT_W    = 20,
  parameter int N_CLUSTER = 4,
  parameter int CL_W      = 2,
  parameter int DEPTH     = 4,
  parameter int CREDITS   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [(3+N_CLUSTER)*FLIT_W-1:0] in_data,
  input  logic [2+N_CLUSTER:0]            in_valid,
  output logic [2+N_CLUSTER:0]            in_credit,
  output logic [(3+N_CLUSTER)*FLIT_W-1:0] out_data,
  output logic [2+N_CLUSTER:0]            out_valid,
  input  logic [2+N_CLUSTER:0]            out_credit,
  input  logic [CL_W-1:0]                 my_cluster,
  output logic [2+N_CLUSTER:0]            err_overflow
);

  localparam int P     = 3 + N_CLUSTER;
  localparam int LOC_W = (N_CLUSTER > 1) ? $clog2(N_CLUSTER) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = $clog2(P);
  localparam int CW    = $clog2(CREDITS + 1);

  localparam logic [LOC_W:0] N_LOCAL   = (LOC_W+1)'(N_CLUSTER);
  localparam logic [CW-1:0]  CRED_MAX  = CW'(CREDITS);
  localparam logic [AW:0]    FIFO_FULL = (AW+1)'(DEPTH);
`ifdef HUB_TILE_SHORTEST_PATH_EN
  localparam logic [CL_W:0]  HALF_RING = (CL_W+1)'((1 << CL_W) / 2);
`endif

  logic [FLIT_W-1:0]          in_data_r   [P];
  logic [P-1:0]               in_valid_r;
  logic [FLIT_W-1:0]          mem_r       [P][DEPTH];
  logic [AW-1:0]              rd_ptr_r    [P];
  logic [AW-1:0]              wr_ptr_r    [P];
  logic [AW:0]                count_r     [P];
  logic [P-1:0]               err_r;
  logic [CW-1:0]              credit_r    [P];
  logic [PW-1:0]              ptr_r       [P];
  logic [P-1:0]               out_valid_r;
  logic [P-1:0]               in_credit_r;
  logic [P*FLIT_W-1:0]        out_data_r;

  logic [FLIT_W-1:0]          head_s      [P];
  logic [PW-1:0]              dest_s      [P];
  logic [P-1:0]               drop_s;
  logic [P-1:0]               busy_s;
  logic [P-1:0]               gnt_s       [P];   // gnt_s[output][input]
  logic [PW-1:0]              win_s       [P];
  logic [P-1:0]               any_gnt_s;
  logic [P-1:0]               deq_s;
  logic [P-1:0]               full_s;
  logic [P-1:0]               wr_s;
  logic [PW-1:0]              arb_idx_s;
  logic                       arb_hit_s;

  // Route decision for one head flit: returns {drop, output index}.
  function automatic logic [PW:0] route_fn(input int port,
                                           input logic [FLIT_W-1:0] flit,
                                           input logic [CL_W-1:0] here);
    logic             sys;
    logic [CL_W-1:0]  dc;
    logic [LOC_W-1:0] dl;
    logic [PW:0]      res;
`ifdef HUB_TILE_SHORTEST_PATH_EN
    logic [CL_W-1:0]  dist;
`endif
    sys = flit[FLIT_W-1];
    dc  = flit[FLIT_W-2 -: CL_W];
    dl  = flit[FLIT_W-2-CL_W -: LOC_W];
    res = {1'b0, PW'(0)};
    // The vertical input never bounces SYS traffic back up; it routes locally.
    if (sys && (port != 32'sd2)) begin
      res = {1'b0, PW'(2)};
    end else if (dc == here) begin
      if ({1'b0, dl} < N_LOCAL) res = {1'b0, PW'(3) + PW'(dl)};
      else                      res = {1'b1, PW'(0)};
    end else begin
`ifdef HUB_TILE_SHORTEST_PATH_EN
      // Modular ring distance wraps naturally in CL_W bits.
      dist = dc - here;
      if ({1'b0, dist} <= HALF_RING) res = {1'b0, PW'(0)};
      else                           res = {1'b0, PW'(1)};
`else
      res = {1'b0, PW'(0)};
`endif
    end
    return res;
  endfunction

  // Entry register: one cycle between the pins and the FIFO write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_valid_r <= '0;
      for (int p = 0; p < P; p++) in_data_r[p] <= '0;
    end else begin
      in_valid_r <= in_valid;
      for (int p = 0; p < P; p++) in_data_r[p] <= in_data[p*FLIT_W +: FLIT_W];
    end
  end

  // Head decode and per-input route.
  always_comb begin
    busy_s = '0;
    drop_s = '0;
    for (int p = 0; p < P; p++) begin
      head_s[p] = mem_r[p][rd_ptr_r[p]];
      dest_s[p] = '0;
      busy_s[p] = (count_r[p] != '0);
      {drop_s[p], dest_s[p]} = route_fn(p, head_s[p], my_cluster);
    end
  end

  // Round-robin arbitration per output, searching from ptr_r, gated by credit.
  always_comb begin
    any_gnt_s = '0;
    arb_idx_s = '0;
    arb_hit_s = 1'b0;
    for (int o = 0; o < P; o++) begin
      gnt_s[o] = '0;
      win_s[o] = '0;
      for (int k = 0; k < P; k++) begin
        arb_idx_s = PW'(((int'(ptr_r[o]) + k) >= P) ? (int'(ptr_r[o]) + k - P)
                                                     : (int'(ptr_r[o]) + k));
        arb_hit_s = (credit_r[o] != '0) && !any_gnt_s[o] && busy_s[arb_idx_s] &&
                    !drop_s[arb_idx_s] && (dest_s[arb_idx_s] == PW'(o));
        gnt_s[o][arb_idx_s] = gnt_s[o][arb_idx_s] | arb_hit_s;
        win_s[o]     = arb_hit_s ? arb_idx_s : win_s[o];
        any_gnt_s[o] = any_gnt_s[o] | arb_hit_s;
      end
    end
  end

  // Dequeue on grant or drop; a full FIFO still accepts when it dequeues.
  always_comb begin
    deq_s = busy_s & drop_s;
    for (int o = 0; o < P; o++) deq_s = deq_s | gnt_s[o];
    for (int p = 0; p < P; p++) full_s[p] = (count_r[p] == FIFO_FULL);
    wr_s = in_valid_r & (~full_s | deq_s);
  end

  // FIFO pointers, occupancy and sticky overflow flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= '0;
      for (int p = 0; p < P; p++) begin
        rd_ptr_r[p] <= '0;
        wr_ptr_r[p] <= '0;
        count_r[p]  <= '0;
      end
    end else begin
      err_r <= err_r | (in_valid_r & full_s & ~deq_s);
      for (int p = 0; p < P; p++) begin
        if (wr_s[p])  wr_ptr_r[p] <= wr_ptr_r[p] + AW'(1);
        if (deq_s[p]) rd_ptr_r[p] <= rd_ptr_r[p] + AW'(1);
        count_r[p] <= count_r[p] + (AW+1)'(wr_s[p]) - (AW+1)'(deq_s[p]);
      end
    end
  end

  // FIFO storage; contents are meaningless while empty, so no reset.
  always_ff @(posedge clk) begin
    for (int p = 0; p < P; p++) begin
      if (wr_s[p]) mem_r[p][wr_ptr_r[p]] <= in_data_r[p];
    end
  end

  // Output registers, RR pointers and per-output credit counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= '0;
      in_credit_r <= '0;
      out_data_r  <= '0;
      for (int o = 0; o < P; o++) begin
        credit_r[o] <= CRED_MAX;
        ptr_r[o]    <= '0;
      end
    end else begin
      out_valid_r <= any_gnt_s;
      in_credit_r <= deq_s;
      for (int o = 0; o < P; o++) begin
        if (any_gnt_s[o]) begin
          out_data_r[o*FLIT_W +: FLIT_W] <= head_s[win_s[o]];
          ptr_r[o] <= (win_s[o] == PW'(P-1)) ? PW'(0) : win_s[o] + PW'(1);
        end
        case ({any_gnt_s[o], out_credit[o]})
          2'b10:   credit_r[o] <= credit_r[o] - CW'(1);
          2'b01:   credit_r[o] <= (credit_r[o] == CRED_MAX) ? credit_r[o]
                                                            : credit_r[o] + CW'(1);
          default: credit_r[o] <= credit_r[o];
        endcase
      end
    end
  end

  assign out_valid    = out_valid_r;
  assign in_credit    = in_credit_r;
  assign out_data     = out_data_r;
  assign err_overflow = err_r;

endmodule
